// File: rtl/stream_arbiter_pkg.sv
// Shared types and constants for the N-input stream arbiter.
package stream_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    SEND
  } state_e;

  localparam int unsigned MODE_ROUND_ROBIN = 0;
  localparam int unsigned MODE_FIXED       = 1;

endpackage

// File: rtl/stream_arbiter_if.sv
// Bundle of the N stb/ack input channels and the tagged output channel.
interface stream_arbiter_if #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned N_INPUTS = 2
);
  localparam int unsigned SRC_WIDTH = $clog2(N_INPUTS);

  logic [N_INPUTS*WIDTH-1:0] inputs;
  logic [N_INPUTS-1:0]       inputs_stb;
  logic [N_INPUTS-1:0]       inputs_ack;
  logic [WIDTH-1:0]          output_z;
  logic [SRC_WIDTH-1:0]      output_z_src;
  logic                      output_z_stb;
  logic                      output_z_ack;

  // Arbiter side.
  modport slave (
    input  inputs, inputs_stb, output_z_ack,
    output inputs_ack, output_z, output_z_src, output_z_stb
  );

  // Producer/consumer side.
  modport master (
    output inputs, inputs_stb, output_z_ack,
    input  inputs_ack, output_z, output_z_src, output_z_stb
  );

endinterface

// File: rtl/stream_arbiter_rr_select.sv
// Combinational winner search: first set request at or above start, wrapping at N_INPUTS-1.
module rr_select #(
  parameter int unsigned N_INPUTS  = 2,
  parameter int unsigned SRC_WIDTH = $clog2(N_INPUTS)
) (
  input  logic [N_INPUTS-1:0]  req,
  input  logic [SRC_WIDTH-1:0] start,
  output logic [SRC_WIDTH-1:0] winner,
  output logic                 any_valid
);

  always_comb begin
    int unsigned idx;
    logic        found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < N_INPUTS; k++) begin
      // Explicit wrap so non-power-of-two channel counts work.
      idx = int'(start) + k;
      if (idx >= N_INPUTS) idx = idx - N_INPUTS;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = SRC_WIDTH'(idx);
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/stream_arbiter.sv
// N-input stb/ack stream arbiter: grants one channel, accepts one word, forwards it tagged.
module stream_arbiter
  import stream_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned N_INPUTS  = 2,
  parameter int unsigned MODE      = MODE_ROUND_ROBIN,
  localparam int unsigned SRC_WIDTH = $clog2(N_INPUTS)
) (
  input logic             clk,
  input logic             rst,
  stream_arbiter_if.slave bus
);

  state_e               state_q, state_d;
  logic [SRC_WIDTH-1:0] grant_q, grant_d;
  logic [SRC_WIDTH-1:0] ptr_q, ptr_d;
  logic [N_INPUTS-1:0]  ack_q, ack_d;
  logic [WIDTH-1:0]     z_q, z_d;
  logic [SRC_WIDTH-1:0] src_q, src_d;
  logic                 stb_q, stb_d;

  logic [SRC_WIDTH-1:0] start;
  logic [SRC_WIDTH-1:0] winner;
  logic                 any_valid;
  logic [SRC_WIDTH-1:0] ptr_next;

  assign start = (MODE == MODE_FIXED) ? '0 : ptr_q;

  rr_select #(
    .N_INPUTS (N_INPUTS),
    .SRC_WIDTH(SRC_WIDTH)
  ) u_rr_select (
    .req      (bus.inputs_stb),
    .start    (start),
    .winner   (winner),
    .any_valid(any_valid)
  );

  assign ptr_next = (grant_q == SRC_WIDTH'(N_INPUTS - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    ack_d   = ack_q;
    z_d     = z_q;
    src_d   = src_q;
    stb_d   = stb_q;
    unique case (state_q)
      IDLE: begin
        ack_d = '0;
        stb_d = 1'b0;
        if (any_valid) begin
          grant_d        = winner;
          ack_d[winner]  = 1'b1;
          state_d        = ACCEPT;
        end
      end
      ACCEPT: begin
        // ack[grant] is high throughout ACCEPT, so stb alone decides transfer vs abort.
        ack_d = '0;
        if (bus.inputs_stb[grant_q]) begin
          z_d     = bus.inputs[int'(grant_q)*WIDTH +: WIDTH];
          src_d   = grant_q;
          stb_d   = 1'b1;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (bus.output_z_ack) begin
          stb_d   = 1'b0;
          state_d = IDLE;
          if (MODE == MODE_ROUND_ROBIN) ptr_d = ptr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      ack_q   <= '0;
      z_q     <= '0;
      src_q   <= '0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      z_q     <= z_d;
      src_q   <= src_d;
      stb_q   <= stb_d;
    end
  end

  assign bus.inputs_ack   = ack_q;
  assign bus.output_z     = z_q;
  assign bus.output_z_src = src_q;
  assign bus.output_z_stb = stb_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Scoreboard bench: three arbiters (N=2 RR, N=3 RR, N=4 fixed) driven by directed vectors.
module tb_stream_arbiter;

  typedef struct packed {
    logic [3:0]  src;
    logic [15:0] data;
  } exp_t;

  logic clk;
  logic rst;

  stream_arbiter_if #(.WIDTH(16), .N_INPUTS(2)) b2 ();
  stream_arbiter_if #(.WIDTH(16), .N_INPUTS(3)) br ();
  stream_arbiter_if #(.WIDTH(16), .N_INPUTS(4)) b4 ();

  stream_arbiter #(.WIDTH(16), .N_INPUTS(2), .MODE(0)) u_two (.clk(clk), .rst(rst), .bus(b2));
  stream_arbiter #(.WIDTH(16), .N_INPUTS(3), .MODE(0)) u_rr  (.clk(clk), .rst(rst), .bus(br));
  stream_arbiter #(.WIDTH(16), .N_INPUTS(4), .MODE(1)) u_fx  (.clk(clk), .rst(rst), .bus(b4));

  exp_t q2[$];
  exp_t q3[$];
  exp_t q4[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_cyc    = 0;
  bit rate_on     = 0;
  bit have_last   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q2.size();
      1:       return q3.size();
      default: return q4.size();
    endcase
  endfunction

  task automatic check_out(input int sel, input exp_t got);
    exp_t want;
    bit   empty;
    want  = '0;
    empty = (qsize(sel) == 0);
    if (!empty) begin
      case (sel)
        0:       want = q2.pop_front();
        1:       want = q3.pop_front();
        default: want = q4.pop_front();
      endcase
    end
    vectors++;
    if (empty) begin
      miscompares++;
      $display("FAIL out%0d unexpected word: got src=%0d data=%h, required none",
               sel, got.src, got.data);
    end else if (got !== want) begin
      miscompares++;
      $display("FAIL out%0d word: got src=%0d data=%h, required src=%0d data=%h",
               sel, got.src, got.data, want.src, want.data);
    end
  endtask

  // At most one ack, and never together with the output strobe.
  task automatic check_inv(input int sel, input logic [15:0] ack, input logic stb);
    vectors++;
    if ($countones(ack) > 1 || (|ack && stb)) begin
      miscompares++;
      $display("FAIL inv%0d: got ack=%b stb=%b, required onehot0 ack and no overlap",
               sel, ack, stb);
    end
  endtask

  task automatic wait_empty(input int sel, input int budget);
    int n = 0;
    while (qsize(sel) != 0 && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("drain%0d", sel), 32'(qsize(sel)), 32'd0);
  endtask

  task automatic wait_rr_stb(input int budget);
    int n = 0;
    while (!br.output_z_stb && n < budget) begin
      tick();
      n++;
    end
    chk("rr_stb_seen", 32'(br.output_z_stb), 32'd1);
  endtask

  function automatic logic [31:0] pack_rr();
    return {10'b0, br.output_z_stb, br.output_z_src, br.inputs_ack, br.output_z};
  endfunction

  function automatic logic [31:0] mk_rr(input logic stb, input logic [1:0] src,
                                        input logic [2:0] ack, input logic [15:0] z);
    return {10'b0, stb, src, ack, z};
  endfunction

  always @(negedge clk) begin
    exp_t g;
    check_inv(0, 16'(b2.inputs_ack), b2.output_z_stb);
    check_inv(1, 16'(br.inputs_ack), br.output_z_stb);
    check_inv(2, 16'(b4.inputs_ack), b4.output_z_stb);
    if (b2.output_z_stb && b2.output_z_ack) begin
      g.src  = 4'(b2.output_z_src);
      g.data = b2.output_z;
      check_out(0, g);
      if (rate_on) begin
        if (have_last) chk("rate_two", 32'(cyc - last_cyc), 32'd3);
        have_last = 1'b1;
        last_cyc  = cyc;
      end
    end
    if (br.output_z_stb && br.output_z_ack) begin
      g.src  = 4'(br.output_z_src);
      g.data = br.output_z;
      check_out(1, g);
    end
    if (b4.output_z_stb && b4.output_z_ack) begin
      g.src  = 4'(b4.output_z_src);
      g.data = b4.output_z;
      check_out(2, g);
    end
  end

  initial begin
    rst = 1'b1;
    b2.inputs = '0; b2.inputs_stb = '0; b2.output_z_ack = 1'b0;
    br.inputs = '0; br.inputs_stb = '0; br.output_z_ack = 1'b0;
    b4.inputs = '0; b4.inputs_stb = '0; b4.output_z_ack = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_two", 32'({b2.output_z_stb, b2.output_z_src, b2.inputs_ack, b2.output_z}), 32'd0);
    chk("rst_rr",  pack_rr(), 32'd0);
    chk("rst_fx",  32'({b4.output_z_stb, b4.output_z_src, b4.inputs_ack, b4.output_z}), 32'd0);
    tick();
    tick();
    rst = 1'b1;

    // N=2 round robin, both requesting: alternate 0,1 at one word per 3 cycles.
    b2.inputs       = {16'h2222, 16'h1111};
    b2.inputs_stb   = 2'b11;
    b2.output_z_ack = 1'b1;
    rate_on         = 1'b1;
    for (int i = 0; i < 6; i++) q2.push_back((i % 2 == 0) ? exp_t'{4'd0, 16'h1111}
                                                          : exp_t'{4'd1, 16'h2222});
    wait_empty(0, 60);
    rate_on       = 1'b0;
    b2.inputs_stb = 2'b00;

    // N=4 fixed priority: channel 0 always wins, then channel 1 once 0 drops.
    b4.inputs       = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
    b4.inputs_stb   = 4'hF;
    b4.output_z_ack = 1'b1;
    for (int i = 0; i < 3; i++) q4.push_back(exp_t'{4'd0, 16'h00A0});
    wait_empty(2, 40);
    b4.inputs_stb = 4'hE;
    q4.push_back(exp_t'{4'd1, 16'h00A1});
    wait_empty(2, 20);
    b4.inputs_stb = 4'h0;

    // N=3 round robin: lone request on 2, then all three served 0,1,2.
    br.inputs       = {16'h00C2, 16'h00C1, 16'h00C0};
    br.inputs_stb   = 3'b100;
    br.output_z_ack = 1'b1;
    q3.push_back(exp_t'{4'd2, 16'h00C2});
    wait_empty(1, 20);
    br.inputs_stb = 3'b111;
    q3.push_back(exp_t'{4'd0, 16'h00C0});
    q3.push_back(exp_t'{4'd1, 16'h00C1});
    q3.push_back(exp_t'{4'd2, 16'h00C2});
    wait_empty(1, 40);
    br.inputs_stb = 3'b000;

    // Backpressure: output held for 10 cycles with no input acknowledged.
    br.output_z_ack = 1'b0;
    br.inputs_stb   = 3'b100;
    wait_rr_stb(20);
    br.inputs_stb = 3'b000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold", pack_rr(), mk_rr(1'b1, 2'd2, 3'b000, 16'h00C2));
    end
    q3.push_back(exp_t'{4'd2, 16'h00C2});
    br.output_z_ack = 1'b1;
    wait_empty(1, 20);
    chk("bp_idle", pack_rr(), mk_rr(1'b0, 2'd2, 3'b000, 16'h00C2));

    // Abort on channel 1 during ACCEPT; pointer must stay at 0.
    br.inputs_stb = 3'b010;
    tick();
    chk("abort_ack", pack_rr(), mk_rr(1'b0, 2'd2, 3'b010, 16'h00C2));
    br.inputs_stb = 3'b000;
    tick();
    chk("abort_drop", pack_rr(), mk_rr(1'b0, 2'd2, 3'b000, 16'h00C2));
    tick();
    chk("abort_idle", pack_rr(), mk_rr(1'b0, 2'd2, 3'b000, 16'h00C2));
    br.inputs_stb = 3'b111;
    q3.push_back(exp_t'{4'd0, 16'h00C0});
    wait_empty(1, 20);
    br.inputs_stb = 3'b000;

    // Asynchronous reset in the middle of SEND discards the word and the pointer.
    br.output_z_ack = 1'b0;
    br.inputs_stb   = 3'b100;
    wait_rr_stb(20);
    br.inputs_stb = 3'b000;
    chk("pre_rst_send", pack_rr(), mk_rr(1'b1, 2'd2, 3'b000, 16'h00C2));
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_send", pack_rr(), 32'd0);
    tick();
    tick();
    #2 rst = 1'b1;
    tick();
    br.inputs_stb   = 3'b101;
    br.output_z_ack = 1'b1;
    q3.push_back(exp_t'{4'd0, 16'h00C0});
    wait_empty(1, 20);
    br.inputs_stb = 3'b000;

    for (int i = 0; i < 5; i++) tick();
    chk("final_q2", 32'(q2.size()), 32'd0);
    chk("final_q3", 32'(q3.size()), 32'd0);
    chk("final_q4", 32'(q4.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
